cz80_bus_arbiter: RTL and testbench

Two-master arbiter that shares the single downstream memory/IO bus between the cz80_wrap CPU (master 0) and a second requester such as a DMA or VDP command engine (master 1). Both upstream ports and the downstream port use the same valid/ready + rdata_en protocol as cz80_wrap. The arbiter registers each granted request and allows at most one downstream transaction in flight. It holds ownership until a read returns, and a read watchdog prevents a lost rdata_en from deadlocking the bus.

---
 rtl/cz80_bus_arbiter_if.sv | 23 ++
 rtl/cz80_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_cz80_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cz80_bus_arbiter_if.sv
// Valid/ready + rdata_en bus shared by the CPU, the second requester and the
// downstream memory/IO port of cz80_bus_arbiter.
interface cz80_bus_arbiter_if;
  logic [15:0] address;
  logic        memreq;
  logic        ioreq;
  logic        write;
  logic [7:0]  wdata;
  logic        valid;
  logic        ready;
  logic [7:0]  rdata;
  logic        rdata_en;

  modport master (
    output address, memreq, ioreq, write, wdata, valid,
    input  ready, rdata, rdata_en
  );

  modport slave (
    input  address, memreq, ioreq, write, wdata, valid,
    output ready, rdata, rdata_en
  );
endinterface

// File: rtl/cz80_bus_arbiter.sv
// Two-master arbiter for the cz80 memory/IO bus: one registered transaction in
// flight, ownership held until a read returns or the read watchdog fires.
module cz80_bus_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned RD_TIMEOUT    = 255
) (
  input  logic               clk_n,
  input  logic               reset_n,
  cz80_bus_arbiter_if.slave  m0,
  cz80_bus_arbiter_if.slave  m1,
  cz80_bus_arbiter_if.master bus,
  output logic               rd_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } state_t;

  localparam logic [9:0] WD_LAST = 10'(RD_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q;
  logic        last_grant_q;
  logic        valid_q;
  logic        memreq_q;
  logic        ioreq_q;
  logic        write_q;
  logic [15:0] address_q;
  logic [7:0]  wdata_q;
  logic [9:0]  wd_q;

  logic        grant_valid;
  logic        grant_sel;
  logic        done;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    done        = 1'b0;
    rd_timeout  = 1'b0;
    m0.ready    = 1'b0;
    m1.ready    = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0.valid || m1.valid) begin
          grant_valid = 1'b1;
          if (m0.valid && m1.valid) begin
            grant_sel = (PRIORITY_MODE == 1) ? 1'b0 : ~last_grant_q;
          end else begin
            grant_sel = m1.valid;
          end
          m0.ready = ~grant_sel;
          m1.ready = grant_sel;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        if (bus.ready) begin
          state_d = write_q ? IDLE : WAIT_RD;
        end
      end

      WAIT_RD: begin
        if (bus.rdata_en) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (wd_q == WD_LAST) begin
          // Lost completion: hand the owner 8'hFF so it cannot hang forever.
          done       = 1'b1;
          rd_timeout = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    m0.rdata_en = done & ~owner_q;
    m1.rdata_en = done &  owner_q;
  end

  assign m0.rdata = (rd_timeout && !owner_q) ? 8'hFF : bus.rdata;
  assign m1.rdata = (rd_timeout &&  owner_q) ? 8'hFF : bus.rdata;

  assign bus.valid   = valid_q;
  assign bus.address = address_q;
  assign bus.memreq  = memreq_q;
  assign bus.ioreq   = ioreq_q;
  assign bus.write   = write_q;
  assign bus.wdata   = wdata_q;

  always_ff @(posedge clk_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      valid_q      <= 1'b0;
      memreq_q     <= 1'b0;
      ioreq_q      <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= 16'h0000;
      wdata_q      <= 8'h00;
      wd_q         <= 10'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            address_q    <= grant_sel ? m1.address : m0.address;
            memreq_q     <= grant_sel ? m1.memreq  : m0.memreq;
            ioreq_q      <= grant_sel ? m1.ioreq   : m0.ioreq;
            write_q      <= grant_sel ? m1.write   : m0.write;
            wdata_q      <= grant_sel ? m1.wdata   : m0.wdata;
            owner_q      <= grant_sel;
            last_grant_q <= grant_sel;
            valid_q      <= 1'b1;
          end
        end

        ISSUE: begin
          if (bus.ready) begin
            valid_q <= 1'b0;
            wd_q    <= 10'd0;
          end
        end

        WAIT_RD: begin
          if (!bus.rdata_en) begin
            wd_q <= wd_q + 10'd1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cz80_bus_arbiter.sv
// Directed bench for cz80_bus_arbiter: scoreboard of expected downstream
// transfers and read completions, plus inline handshake checks.
module tb_cz80_bus_arbiter;

  logic clk_n = 1'b0;
  logic reset_n;
  logic rd_timeout;
  logic f_rd_timeout;

  always #5 clk_n = ~clk_n;

  cz80_bus_arbiter_if m0_if ();
  cz80_bus_arbiter_if m1_if ();
  cz80_bus_arbiter_if bus_if ();
  cz80_bus_arbiter_if f0_if ();
  cz80_bus_arbiter_if f1_if ();
  cz80_bus_arbiter_if fbus_if ();

  cz80_bus_arbiter #(.PRIORITY_MODE(0), .RD_TIMEOUT(8)) dut (
    .clk_n      (clk_n),
    .reset_n    (reset_n),
    .m0         (m0_if),
    .m1         (m1_if),
    .bus        (bus_if),
    .rd_timeout (rd_timeout)
  );

  cz80_bus_arbiter #(.PRIORITY_MODE(1), .RD_TIMEOUT(255)) dut_fp (
    .clk_n      (clk_n),
    .reset_n    (reset_n),
    .m0         (f0_if),
    .m1         (f1_if),
    .bus        (fbus_if),
    .rd_timeout (f_rd_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  // {write, memreq, ioreq, address, wdata}
  logic [26:0] bus_q[$];
  // {m1_rdata_en, m0_rdata_en, rdata, rd_timeout}
  logic [10:0] rd_q[$];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_n);
    #1;
  endtask

  function automatic logic [26:0] be(input logic w, input logic mr, input logic io,
                                     input logic [15:0] a, input logic [7:0] d);
    return {w, mr, io, a, d};
  endfunction

  always @(negedge clk_n) begin
    if (bus_if.valid && bus_if.ready) begin
      check("bus_q_pending", 32'(bus_q.size() != 0), 32'd1);
      if (bus_q.size() != 0)
        check("bus_xfer",
              32'({bus_if.write, bus_if.memreq, bus_if.ioreq, bus_if.address, bus_if.wdata}),
              32'(bus_q.pop_front()));
    end
    if (m0_if.rdata_en || m1_if.rdata_en) begin
      check("rd_q_pending", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0)
        check("rd_done",
              32'({m1_if.rdata_en, m0_if.rdata_en,
                   (m1_if.rdata_en ? m1_if.rdata : m0_if.rdata), rd_timeout}),
              32'(rd_q.pop_front()));
    end
  end

  initial begin
    reset_n = 1'b0;
    {m0_if.valid, m0_if.write, m0_if.memreq, m0_if.ioreq} = 4'b0;
    {m1_if.valid, m1_if.write, m1_if.memreq, m1_if.ioreq} = 4'b0;
    m0_if.address = 16'h0; m0_if.wdata = 8'h0;
    m1_if.address = 16'h0; m1_if.wdata = 8'h0;
    bus_if.ready = 1'b1; bus_if.rdata = 8'h00; bus_if.rdata_en = 1'b0;
    {f0_if.valid, f0_if.write, f0_if.memreq, f0_if.ioreq} = 4'b0;
    {f1_if.valid, f1_if.write, f1_if.memreq, f1_if.ioreq} = 4'b0;
    f0_if.address = 16'h0; f0_if.wdata = 8'h0;
    f1_if.address = 16'h0; f1_if.wdata = 8'h0;
    fbus_if.ready = 1'b1; fbus_if.rdata = 8'h3C; fbus_if.rdata_en = 1'b0;

    // Reset state
    step(); step();
    @(negedge clk_n);
    check("rst_bus_valid", 32'(bus_if.valid), 32'd0);
    check("rst_bus_addr",  32'(bus_if.address), 32'd0);
    check("rst_bus_wdata", 32'(bus_if.wdata), 32'd0);
    check("rst_bus_ctrl",  32'({bus_if.memreq, bus_if.ioreq, bus_if.write}), 32'd0);
    check("rst_outputs",   32'({m1_if.ready, m0_if.ready, m1_if.rdata_en, m0_if.rdata_en, rd_timeout}), 32'd0);
    step();
    reset_n = 1'b1;

    // Round-robin contention, both masters hold write requests
    m0_if.valid = 1'b1; m0_if.write = 1'b1; m0_if.memreq = 1'b1; m0_if.ioreq = 1'b0;
    m0_if.address = 16'h0011; m0_if.wdata = 8'hA5;
    m1_if.valid = 1'b1; m1_if.write = 1'b1; m1_if.memreq = 1'b0; m1_if.ioreq = 1'b1;
    m1_if.address = 16'h0012; m1_if.wdata = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) bus_q.push_back(be(1'b1, 1'b1, 1'b0, 16'h0011, 8'hA5));
      else            bus_q.push_back(be(1'b1, 1'b0, 1'b1, 16'h0012, 8'h5A));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_n);
      check("rr_m0_ready", 32'(m0_if.ready), 32'(i % 2 == 0));
      check("rr_m1_ready", 32'(m1_if.ready), 32'(i % 2 == 1));
      step();
      if (i == 3) begin
        m0_if.valid = 1'b0;
        m1_if.valid = 1'b0;
      end
      @(negedge clk_n);
      check("rr_bus_valid", 32'(bus_if.valid), 32'd1);
      check("rr_no_ready",  32'({m1_if.ready, m0_if.ready}), 32'd0);
      step();
    end

    // Single read by m0
    m0_if.valid = 1'b1; m0_if.write = 1'b0; m0_if.memreq = 1'b1; m0_if.ioreq = 1'b0;
    m0_if.address = 16'h0010; m0_if.wdata = 8'h00;
    bus_q.push_back(be(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00));
    @(negedge clk_n);
    check("rd_m0_ready", 32'(m0_if.ready), 32'd1);
    check("rd_m1_ready", 32'(m1_if.ready), 32'd0);
    step();
    m0_if.valid = 1'b0;
    @(negedge clk_n);
    check("rd_bus_valid", 32'(bus_if.valid), 32'd1);
    check("rd_bus_addr",  32'(bus_if.address), 32'h0010);
    step();
    bus_if.rdata = 8'h12; bus_if.rdata_en = 1'b1;
    rd_q.push_back({1'b0, 1'b1, 8'h12, 1'b0});
    @(negedge clk_n);
    check("rd_m1_en", 32'(m1_if.rdata_en), 32'd0);
    step();
    bus_if.rdata_en = 1'b0;

    // Downstream stall with m0 waiting
    m1_if.valid = 1'b1; m1_if.write = 1'b1; m1_if.memreq = 1'b1; m1_if.ioreq = 1'b0;
    m1_if.address = 16'h0200; m1_if.wdata = 8'h3C;
    bus_if.ready = 1'b0;
    bus_q.push_back(be(1'b1, 1'b1, 1'b0, 16'h0200, 8'h3C));
    bus_q.push_back(be(1'b1, 1'b1, 1'b0, 16'h0300, 8'h77));
    @(negedge clk_n);
    check("st_m1_ready", 32'(m1_if.ready), 32'd1);
    step();
    m1_if.valid = 1'b0;
    m0_if.valid = 1'b1; m0_if.write = 1'b1; m0_if.memreq = 1'b1; m0_if.ioreq = 1'b0;
    m0_if.address = 16'h0300; m0_if.wdata = 8'h77;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_n);
      check("st_valid", 32'(bus_if.valid), 32'd1);
      check("st_addr",  32'(bus_if.address), 32'h0200);
      check("st_wdata", 32'(bus_if.wdata), 32'h3C);
      check("st_ready", 32'({m1_if.ready, m0_if.ready}), 32'd0);
      step();
    end
    bus_if.ready = 1'b1;
    step();
    @(negedge clk_n);
    check("st_m0_grant", 32'(m0_if.ready), 32'd1);
    step();
    m0_if.valid = 1'b0;
    step();

    // Watchdog on an m1 read
    m1_if.valid = 1'b1; m1_if.write = 1'b0; m1_if.memreq = 1'b1; m1_if.ioreq = 1'b0;
    m1_if.address = 16'h0400; m1_if.wdata = 8'h00;
    bus_if.rdata = 8'h99;
    bus_q.push_back(be(1'b0, 1'b1, 1'b0, 16'h0400, 8'h00));
    @(negedge clk_n);
    check("wd_grant", 32'(m1_if.ready), 32'd1);
    step();
    m1_if.valid = 1'b0;
    step();
    rd_q.push_back({1'b1, 1'b0, 8'hFF, 1'b1});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_n);
      check("wd_pulse", 32'(rd_timeout), 32'(k == 7));
      step();
    end

    // Back in IDLE: m0 read, then reset while waiting for its data
    m0_if.valid = 1'b1; m0_if.write = 1'b0; m0_if.memreq = 1'b1; m0_if.ioreq = 1'b0;
    m0_if.address = 16'h0500; m0_if.wdata = 8'h00;
    bus_q.push_back(be(1'b0, 1'b1, 1'b0, 16'h0500, 8'h00));
    @(negedge clk_n);
    check("wd_after", 32'({rd_timeout, m1_if.rdata_en, m0_if.rdata_en}), 32'd0);
    check("wd_idle_grant", 32'(m0_if.ready), 32'd1);
    step();
    m0_if.valid = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    bus_if.rdata = 8'h55; bus_if.rdata_en = 1'b1;
    @(negedge clk_n);
    check("rs_bus_valid", 32'(bus_if.valid), 32'd0);
    check("rs_no_rdata_en", 32'({m1_if.rdata_en, m0_if.rdata_en}), 32'd0);
    step();
    bus_if.rdata_en = 1'b0;
    m0_if.valid = 1'b1; m0_if.write = 1'b1; m0_if.memreq = 1'b1; m0_if.ioreq = 1'b0;
    m0_if.address = 16'h0600; m0_if.wdata = 8'h11;
    m1_if.valid = 1'b1; m1_if.write = 1'b1; m1_if.memreq = 1'b0; m1_if.ioreq = 1'b1;
    m1_if.address = 16'h0700; m1_if.wdata = 8'h22;
    bus_q.push_back(be(1'b1, 1'b1, 1'b0, 16'h0600, 8'h11));
    bus_q.push_back(be(1'b1, 1'b0, 1'b1, 16'h0700, 8'h22));
    @(negedge clk_n);
    check("rs_m0_wins", 32'(m0_if.ready), 32'd1);
    check("rs_m1_wait", 32'(m1_if.ready), 32'd0);
    step();
    m0_if.valid = 1'b0;
    step();
    @(negedge clk_n);
    check("rs_m1_grant", 32'(m1_if.ready), 32'd1);
    step();
    m1_if.valid = 1'b0;
    step();

    // Fixed priority instance: m0 keeps winning until it drops valid
    f0_if.valid = 1'b1; f0_if.write = 1'b1; f0_if.memreq = 1'b1;
    f0_if.address = 16'h0011; f0_if.wdata = 8'hA5;
    f1_if.valid = 1'b1; f1_if.write = 1'b1; f1_if.ioreq = 1'b1;
    f1_if.address = 16'h0012; f1_if.wdata = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_n);
      check("fp_m0_ready", 32'(f0_if.ready), 32'd1);
      check("fp_m1_ready", 32'(f1_if.ready), 32'd0);
      step();
      if (i == 2) f0_if.valid = 1'b0;
      @(negedge clk_n);
      check("fp_wdata", 32'(fbus_if.wdata), 32'hA5);
      check("fp_m1_hold", 32'(f1_if.ready), 32'd0);
      step();
    end
    @(negedge clk_n);
    check("fp_m1_grant", 32'(f1_if.ready), 32'd1);
    step();
    f1_if.valid = 1'b0;
    @(negedge clk_n);
    check("fp_m1_addr", 32'({fbus_if.address, fbus_if.wdata}), 32'h0012_5A);
    check("fp_quiet", 32'({f_rd_timeout, f1_if.rdata_en, f0_if.rdata_en}), 32'd0);
    check("fp_rdata_pass", 32'({f0_if.rdata, f1_if.rdata}), 32'h3C3C);
    step();

    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("rd_q_drained",  32'(rd_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
